alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset:
  - clk  input  1  rising-edge clock
  - rst  input  1  synchronous, active-high reset
REQ-002 The block SHALL have, per requester k in {0,1}:
  - req_valid_k  input  1  operation request
  - req_ready_k  output  1  request accepted this cycle
  - req_a_k  input  32  operand a
  - req_b_k  input  32  operand b
  - req_sel_k  input  4  ALU function select
  - rsp_valid_k  output  1  result available for requester k
  - rsp_ready_k  input  1  requester k consumes result
REQ-003 The block SHALL have:
  - rsp_y  output  32  registered result (shared by both requesters)
  - rsp_zero  output  1  registered zero flag
  - alu_a  output  32  shared ALU operand a
  - alu_b  output  32  shared ALU operand b
  - alu_sel  output  4  shared ALU select
  - alu_y  input  32  ALU result
  - alu_zero  input  1  ALU zero flag

Function
REQ-004 The block SHALL be a FSM with states IDLE, EXEC and RESP.
REQ-005 IDLE: if any req_valid_k is high, the block SHALL assert req_ready for exactly one granted requester, combinationally in that cycle; req_ready_k SHALL be 0 in EXEC and RESP.
REQ-006 On an accept edge, the block SHALL latch req_a/req_b/req_sel of the granted requester into op registers, record the grant index, and go to EXEC.
REQ-007 alu_a/alu_b/alu_sel SHALL always be driven from the op registers; the ALU is never driven directly from request inputs.
REQ-008 EXEC: the block SHALL capture alu_y into rsp_y and alu_zero into rsp_zero at the next edge and go to RESP (ALU treated as single-cycle combinational).
REQ-009 RESP: the block SHALL hold rsp_valid_g high for the granted requester g only; rsp_y/rsp_zero SHALL remain stable.
REQ-010 RESP: when rsp_ready_g is high, the block SHALL go to IDLE at that edge; it SHALL wait indefinitely while rsp_ready_g is low.
REQ-011 The block SHALL ignore rsp_ready of the non-granted requester.
REQ-012 Latency SHALL be 2 cycles from accept edge to rsp_valid high; minimum issue interval SHALL be 3 cycles.
REQ-013 Default arbitration SHALL be round-robin:
  - a 1-bit last-grant pointer is updated on each accept;
  - on simultaneous requests, the requester not granted last wins;
  - a single requester is granted regardless of the pointer.
REQ-014 req_sel SHALL pass through unmodified; all 16 codes are legal and the block applies no decoding.
REQ-015 Each requester SHALL hold its request signals stable while req_valid is high and req_ready is low.

Reset
REQ-016 When rst is high at a clock edge, the block SHALL enter IDLE and clear to 0: the pointer (requester 0 favoured), op registers, rsp_y, rsp_zero, rsp_valid_0/1 and req_ready_0/1.
REQ-017 Reset during EXEC or RESP SHALL drop the in-flight operation; no rsp_valid is produced for it.
REQ-018 rst SHALL take priority over a simultaneous request or rsp_ready.

Configuration
REQ-019 With ALU_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win simultaneous requests and the round-robin pointer SHALL be omitted.
REQ-020 Without ALU_ARB_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-013.

Verification
REQ-021 Requester 0 only, a=5, b=3, sel=0000 -> alu_sel=0000 during EXEC; rsp_valid_0=1 two cycles after accept; rsp_y=8, rsp_zero=0.
REQ-022 Requester 1 only, a=7, b=7, sel=0001 -> rsp_y=0, rsp_zero=1; rsp_valid_1 only, rsp_valid_0 stays 0.
REQ-023 Both requesting continuously after reset (round-robin) -> grants in order 0,1,0,1; rsp_y values match each requester's operands (e.g. req0 1 OR 2 = 3, req1 0xFFFFFFFF AND 0x0F = 0x0F).
REQ-024 Same as REQ-023 with ALU_ARB_FIXED_PRIO_EN defined -> requester 0 granted every time; requester 1 is never granted while req_valid_0 stays high.
REQ-025 rsp_ready_0 held low 5 cycles in RESP with rsp_ready_1=1 -> rsp_valid_0 and rsp_y held; req_ready_1=0 throughout; IDLE on the cycle after rsp_ready_0 rises.
REQ-026 rst asserted in EXEC -> next cycle state IDLE, rsp_valid_0/1=0, rsp_y=0; no response for the dropped operation.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one external single-cycle combinational ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_0,
   output logic        req_ready_0,
   input  logic [31:0] req_a_0,
   input  logic [31:0] req_b_0,
   input  logic [3:0]  req_sel_0,
   output logic        rsp_valid_0,
   input  logic        rsp_ready_0,
   input  logic        req_valid_1,
   output logic        req_ready_1,
   input  logic [31:0] req_a_1,
   input  logic [31:0] req_b_1,
   input  logic [3:0]  req_sel_1,
   output logic        rsp_valid_1,
   input  logic        rsp_ready_1,
   output logic [31:0] rsp_y,
   output logic        rsp_zero,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_sel,
   input  logic [31:0] alu_y,
   input  logic        alu_zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] opA_q, opA_d;
   logic [31:0] opB_q, opB_d;
   logic [3:0]  opSel_q, opSel_d;
   logic        grant_q, grant_d;
   logic [31:0] rspY_q, rspY_d;
   logic        rspZero_q, rspZero_d;

   logic anyValid;
   logic grantIdx;
   logic accept;
   logic grantRspReady;

   assign anyValid      = req_valid_0 | req_valid_1;
   assign accept        = (state_q == IDLE) && anyValid && !rst;
   assign grantRspReady = grant_q ? rsp_ready_1 : rsp_ready_0;

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign grantIdx = !req_valid_0;
`else
   // ptr_q names the requester that wins the next tie, i.e. the one not granted last
   logic ptr_q, ptr_d;

   assign grantIdx = (req_valid_0 && req_valid_1) ? ptr_q : req_valid_1;

   always_comb begin
      ptr_d = ptr_q;
      if (accept) begin
         ptr_d = ~grantIdx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (anyValid) begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            state_d = RESP;
         end
         RESP: begin
            if (grantRspReady) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      req_ready_0 = 1'b0;
      req_ready_1 = 1'b0;
      rsp_valid_0 = 1'b0;
      rsp_valid_1 = 1'b0;
      if (accept) begin
         req_ready_0 = !grantIdx;
         req_ready_1 = grantIdx;
      end
      if (state_q == RESP) begin
         rsp_valid_0 = !grant_q;
         rsp_valid_1 = grant_q;
      end
   end

   // Operands are captured at accept so the ALU only ever sees registered values
   always_comb begin
      opA_d     = opA_q;
      opB_d     = opB_q;
      opSel_d   = opSel_q;
      grant_d   = grant_q;
      rspY_d    = rspY_q;
      rspZero_d = rspZero_q;
      if (accept) begin
         grant_d = grantIdx;
         opA_d   = grantIdx ? req_a_1   : req_a_0;
         opB_d   = grantIdx ? req_b_1   : req_b_0;
         opSel_d = grantIdx ? req_sel_1 : req_sel_0;
      end
      if (state_q == EXEC) begin
         rspY_d    = alu_y;
         rspZero_d = alu_zero;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         opA_q     <= 32'd0;
         opB_q     <= 32'd0;
         opSel_q   <= 4'd0;
         grant_q   <= 1'b0;
         rspY_q    <= 32'd0;
         rspZero_q <= 1'b0;
      end else begin
         opA_q     <= opA_d;
         opB_q     <= opB_d;
         opSel_q   <= opSel_d;
         grant_q   <= grant_d;
         rspY_q    <= rspY_d;
         rspZero_q <= rspZero_d;
      end
   end

   assign alu_a    = opA_q;
   assign alu_b    = opB_q;
   assign alu_sel  = opSel_q;
   assign rsp_y    = rspY_q;
   assign rsp_zero = rspZero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus randomized traffic checked against a transaction-level model.
// Compile with ALU_ARB_FIXED_PRIO_EN defined to exercise the fixed-priority build.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_0, req_ready_0, rsp_valid_0, rsp_ready_0;
   logic        req_valid_1, req_ready_1, rsp_valid_1, rsp_ready_1;
   logic [31:0] req_a_0, req_b_0, req_a_1, req_b_1;
   logic [3:0]  req_sel_0, req_sel_1;
   logic [31:0] rsp_y, alu_a, alu_b, alu_y;
   logic        rsp_zero, alu_zero;
   logic [3:0]  alu_sel;

   int nChecks = 0;
   int nFails  = 0;

   always #5 clk = ~clk;

   // External ALU the arbiter fronts
   function automatic logic [31:0] aluFn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
      case (s)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return a << b[4:0];
         4'd6:    return a >> b[4:0];
         4'd7:    return ~(a | b);
         default: return a ^ {b[15:0], b[31:16]} ^ {28'd0, s};
      endcase
   endfunction

   assign alu_y    = aluFn(alu_a, alu_b, alu_sel);
   assign alu_zero = (alu_y == 32'd0);

   alu_arbiter dut (
      .clk(clk), .rst(rst),
      .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_a_0(req_a_0), .req_b_0(req_b_0),
      .req_sel_0(req_sel_0), .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0),
      .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_a_1(req_a_1), .req_b_1(req_b_1),
      .req_sel_1(req_sel_1), .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1),
      .rsp_y(rsp_y), .rsp_zero(rsp_zero),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y), .alu_zero(alu_zero)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nChecks++;
      if (observed !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Transaction-level model: phase 0 waiting, 1 computing, 2 presenting a result
   int          mPhase = 0;
   bit          mArmed = 0;
   logic        mLast = 1'b1;
   logic        mOwner = 1'b0;
   logic        mAcc, mWin;
   logic [31:0] mA = 0, mB = 0, mY = 0;
   logic [3:0]  mSel = 0;
   logic        mZ = 1'b0;

   task automatic settle();
      #1;
      mAcc = (mPhase == 0) && !rst && (req_valid_0 || req_valid_1);
`ifdef ALU_ARB_FIXED_PRIO_EN
      if (req_valid_0) mWin = 1'b0;
      else             mWin = 1'b1;
`else
      if (req_valid_0 && req_valid_1) mWin = !mLast;
      else if (req_valid_0)           mWin = 1'b0;
      else                            mWin = 1'b1;
`endif
      if (mArmed) begin
         checkOutput("req_ready_0", req_ready_0, mAcc && (mWin == 1'b0));
         checkOutput("req_ready_1", req_ready_1, mAcc && (mWin == 1'b1));
         checkOutput("rsp_valid_0", rsp_valid_0, (mPhase == 2) && (mOwner == 1'b0));
         checkOutput("rsp_valid_1", rsp_valid_1, (mPhase == 2) && (mOwner == 1'b1));
         checkOutput("rsp_y", rsp_y, mY);
         checkOutput("rsp_zero", rsp_zero, mZ);
         checkOutput("alu_a", alu_a, mA);
         checkOutput("alu_b", alu_b, mB);
         checkOutput("alu_sel", alu_sel, mSel);
      end
   endtask

   task automatic advance();
      @(posedge clk);
      if (rst) begin
         mPhase = 0; mLast = 1'b1; mA = 0; mB = 0; mSel = 0; mY = 0; mZ = 1'b0; mArmed = 1;
      end else if (mPhase == 0) begin
         if (mAcc) begin
            mOwner = mWin;
            mLast  = mWin;
            mA     = mWin ? req_a_1 : req_a_0;
            mB     = mWin ? req_b_1 : req_b_0;
            mSel   = mWin ? req_sel_1 : req_sel_0;
            mPhase = 1;
         end
      end else if (mPhase == 1) begin
         mY     = aluFn(mA, mB, mSel);
         mZ     = (mY == 32'd0);
         mPhase = 2;
      end else if ((mOwner ? rsp_ready_1 : rsp_ready_0)) begin
         mPhase = 0;
      end
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic r,
                                input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                                input logic [3:0] s0, input logic rr0,
                                input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                                input logic [3:0] s1, input logic rr1);
      rst = r;
      req_valid_0 = v0; req_a_0 = a0; req_b_0 = b0; req_sel_0 = s0; rsp_ready_0 = rr0;
      req_valid_1 = v1; req_a_1 = a1; req_b_1 = b1; req_sel_1 = s1; rsp_ready_1 = rr1;
   endtask

   task automatic doReset();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      advance();
   endtask

   logic expGrant;
   logic p0, p1;

   initial begin
      // Reset state
      doReset();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      checkOutput("rst_rsp_y", rsp_y, 32'd0);
      checkOutput("rst_rsp_valid_0", rsp_valid_0, 1'b0);
      checkOutput("rst_alu_a", alu_a, 32'd0);
      advance();

      // Requester 0 alone: 5 + 3
      applyStimulus(0, 1, 32'd5, 32'd3, 4'd0, 0, 0, 0, 0, 0, 0);
      settle();
      checkOutput("t21_ready_0", req_ready_0, 1'b1);
      advance();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      checkOutput("t21_exec_sel", alu_sel, 4'd0);
      checkOutput("t21_exec_valid", rsp_valid_0, 1'b0);
      advance();
      rsp_ready_0 = 1'b1;
      settle();
      checkOutput("t21_valid_0", rsp_valid_0, 1'b1);
      checkOutput("t21_y", rsp_y, 32'd8);
      checkOutput("t21_zero", rsp_zero, 1'b0);
      advance();

      // Requester 1 alone: 7 - 7
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'd7, 32'd7, 4'd1, 0);
      settle();
      advance();
      req_valid_1 = 1'b0;
      settle();
      advance();
      rsp_ready_1 = 1'b1;
      rsp_ready_0 = 1'b1;
      settle();
      checkOutput("t22_valid_1", rsp_valid_1, 1'b1);
      checkOutput("t22_valid_0", rsp_valid_0, 1'b0);
      checkOutput("t22_y", rsp_y, 32'd0);
      checkOutput("t22_zero", rsp_zero, 1'b1);
      advance();

      // Both requesting continuously after reset
      doReset();
      applyStimulus(0, 1, 32'd1, 32'd2, 4'd3, 1, 1, 32'hFFFF_FFFF, 32'h0F, 4'd2, 1);
      for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         expGrant = 1'b0;
`else
         expGrant = (i % 2) == 1;
`endif
         settle();
         checkOutput("t23_grant_0", req_ready_0, !expGrant);
         checkOutput("t23_grant_1", req_ready_1, expGrant);
         advance();
         settle();
         advance();
         settle();
         checkOutput("t23_y", rsp_y, expGrant ? 32'h0F : 32'd3);
         advance();
      end

      // Requester 0 stalls its response while requester 1 waits
      doReset();
      applyStimulus(0, 1, 32'd10, 32'd20, 4'd0, 0, 1, 32'd4, 32'd4, 4'd4, 1);
      settle();
      advance();
      req_valid_0 = 1'b0;
      settle();
      advance();
      for (int i = 0; i < 5; i++) begin
         settle();
         checkOutput("t25_valid_0", rsp_valid_0, 1'b1);
         checkOutput("t25_y", rsp_y, 32'd30);
         checkOutput("t25_ready_1", req_ready_1, 1'b0);
         advance();
      end
      rsp_ready_0 = 1'b1;
      settle();
      advance();
      settle();
      checkOutput("t25_idle_ready_1", req_ready_1, 1'b1);
      advance();
      req_valid_1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         advance();
      end

      // Reset during EXEC drops the operation
      doReset();
      applyStimulus(0, 1, 32'd5, 32'd3, 4'd0, 1, 0, 0, 0, 0, 1);
      settle();
      advance();
      applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
      settle();
      advance();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         checkOutput("t26_valid_0", rsp_valid_0, 1'b0);
         checkOutput("t26_y", rsp_y, 32'd0);
         advance();
      end

      // Randomized traffic; requests stay stable until accepted
      p0 = 1'b0;
      p1 = 1'b0;
      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(0, 39) == 0);
         if (!p0 && $urandom_range(0, 2) == 0) begin
            p0 = 1'b1;
            req_a_0 = $urandom;
            req_b_0 = ($urandom_range(0, 3) == 0) ? req_a_0 : $urandom;
            req_sel_0 = 4'($urandom_range(0, 15));
         end
         if (!p1 && $urandom_range(0, 2) == 0) begin
            p1 = 1'b1;
            req_a_1 = $urandom;
            req_b_1 = ($urandom_range(0, 3) == 0) ? req_a_1 : $urandom;
            req_sel_1 = 4'($urandom_range(0, 15));
         end
         req_valid_0 = p0;
         req_valid_1 = p1;
         rsp_ready_0 = 1'($urandom_range(0, 1));
         rsp_ready_1 = 1'($urandom_range(0, 1));
         settle();
         advance();
         if (mAcc) begin
            if (mWin) p1 = 1'b0;
            else      p0 = 1'b0;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
